// File: rtl/inst_fetch_decode.sv
// Instruction fetch/decode stage: owns the PC, fetches over a req/ack handshake,
// holds the word in an instruction register and presents decoded fields over valid/ready.
module inst_fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jaddr,
  output logic        ext_sel,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        squash_q, squash_d;
  logic [31:0] redir_pc;

  assign redir_pc = redirect_pc & ~32'h0000_0003;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RST;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      ir_q     <= 32'h0;
      pc_out_q <= RESET_PC;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      ir_q     <= ir_d;
      pc_out_q <= pc_out_d;
      squash_q <= squash_d;
    end
  end

  // addr_q is the address on the bus; it only follows pc while no request is
  // outstanding, so a redirect during a pending fetch leaves the bus stable.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    ir_d     = ir_q;
    pc_out_d = pc_out_q;
    squash_d = squash_q;
    case (state_q)
      ST_RST: begin
        if (redirect) pc_d = redir_pc;
        addr_d  = pc_d;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect) begin
          pc_d     = redir_pc;
          squash_d = !imem_ack;
        end else if (imem_ack) begin
          if (squash_q) begin
            squash_d = 1'b0;
          end else begin
            ir_d     = imem_rdata;
            pc_out_d = pc_q;
            state_d  = ST_HOLD;
          end
        end
        if (imem_ack) addr_d = pc_d;
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redir_pc;
          state_d = ST_FETCH;
        end else if (out_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = ST_FETCH;
        end
        addr_d = pc_d;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = addr_q;
  assign out_valid = (state_q == ST_HOLD);

  assign instr    = ir_q;
  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm16    = ir_q[15:0];
  assign jaddr    = ir_q[25:0];
  // ANDI/ORI/XORI/LUI (0x0C..0x0F) share the 4-bit prefix 4'b0011
  assign ext_sel  = (ir_q[31:28] == 4'b0011);
  assign pc_out   = pc_out_q;
  assign pc_plus4 = pc_out_q + 32'd4;

endmodule

// File: tb/tb_inst_fetch_decode.sv
// Self-checking bench for inst_fetch_decode: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_inst_fetch_decode;

  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPCW = 32'hFFFF_FFFC;

  logic        clk;
  logic        reset_n, imem_ack, redirect, out_ready;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, out_valid, ext_sel;
  logic [31:0] imem_addr, instr, pc_out, pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] jaddr;

  logic        w_reset_n, w_imem_ack, w_redirect, w_out_ready;
  logic [31:0] w_imem_rdata, w_redirect_pc;
  logic        w_imem_req, w_out_valid, w_ext_sel;
  logic [31:0] w_imem_addr, w_instr, w_pc_out, w_pc_plus4;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm16;
  logic [25:0] w_jaddr;

  int total = 0;
  int bad   = 0;

  // reference model: phase 0 = just out of reset, 1 = requesting, 2 = holding
  int          m_phase;
  logic [31:0] m_pc, m_addr, m_ir, m_pc_out;
  bit          m_discard;

  inst_fetch_decode #(.RESET_PC(RPC0)) u_dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .funct(funct), .imm16(imm16), .jaddr(jaddr), .ext_sel(ext_sel),
    .pc_out(pc_out), .pc_plus4(pc_plus4)
  );

  inst_fetch_decode #(.RESET_PC(RPCW)) u_dut_wrap (
    .clk(clk), .reset_n(w_reset_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .instr(w_instr), .opcode(w_opcode), .rs(w_rs), .rt(w_rt), .rd(w_rd), .shamt(w_shamt),
    .funct(w_funct), .imm16(w_imm16), .jaddr(w_jaddr), .ext_sel(w_ext_sel),
    .pc_out(w_pc_out), .pc_plus4(w_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset;
    m_phase = 0; m_pc = RPC0; m_addr = RPC0; m_ir = 32'h0; m_pc_out = RPC0; m_discard = 0;
  endtask

  task automatic model_step;
    logic [31:0] tgt;
    tgt = redirect_pc & ~32'h3;
    case (m_phase)
      0: begin
        if (redirect) m_pc = tgt;
        m_addr = m_pc; m_phase = 1;
      end
      1: begin
        if (redirect) begin
          m_pc = tgt;
          if (imem_ack) begin m_discard = 0; m_addr = tgt; end
          else m_discard = 1;
        end else if (imem_ack) begin
          if (m_discard) begin m_discard = 0; m_addr = m_pc; end
          else begin m_ir = imem_rdata; m_pc_out = m_pc; m_phase = 2; end
        end
      end
      default: begin
        if (redirect) begin m_pc = tgt; m_addr = tgt; m_phase = 1; end
        else if (out_ready) begin m_pc = m_pc + 32'd4; m_addr = m_pc; m_phase = 1; end
      end
    endcase
  endtask

  // drives one cycle of inputs from a negedge, ends on the next negedge
  task automatic step(input logic r, input logic [31:0] rpc, input logic ack,
                      input logic [31:0] rdat, input logic rdy);
    redirect = r; redirect_pc = rpc; imem_ack = ack; imem_rdata = rdat; out_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset;
    total++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || ext_sel !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: req=%b valid=%b ext=%b want 0 0 0", imem_req, out_valid, ext_sel);
    end
    total++;
    if (instr !== 32'h0 || opcode !== 6'h0 || imm16 !== 16'h0 || jaddr !== 26'h0) begin
      bad++; $display("FAIL reset_fields: instr=%h want 0", instr);
    end
    total++;
    if (pc_out !== RPC0 || pc_plus4 !== 32'h4 || imem_addr !== RPC0) begin
      bad++; $display("FAIL reset_pc: pc_out=%h pc_plus4=%h addr=%h want 0 4 0", pc_out, pc_plus4, imem_addr);
    end
    step(0, 0, 0, 0, 0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RPC0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL first_req: req=%b addr=%h want 1 %h", imem_req, imem_addr, RPC0);
    end
  endtask

  task automatic test_stream;
    logic [31:0] words [3] = '{32'h3C01_1234, 32'h2002_FFF8, 32'h3443_8000};
    logic [15:0] imms  [3] = '{16'h1234, 16'hFFF8, 16'h8000};
    logic        exts  [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i) || out_valid !== 1'b0) begin
        bad++; $display("FAIL stream_req%0d: req=%b addr=%h want 1 %h", i, imem_req, imem_addr, 32'(4 * i));
      end
      step(0, 0, 1, words[i], 1);
      total++;
      if (out_valid !== 1'b1 || pc_out !== 32'(4 * i) || imm16 !== imms[i] || ext_sel !== exts[i] ||
          instr !== words[i] || imem_req !== 1'b0) begin
        bad++; $display("FAIL stream_out%0d: valid=%b pc=%h imm=%h ext=%b want 1 %h %h %b",
                        i, out_valid, pc_out, imm16, ext_sel, 32'(4 * i), imms[i], exts[i]);
      end
      step(0, 0, 0, 0, 1);
    end
  endtask

  task automatic test_ack_delay;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hC || out_valid !== 1'b0) begin
        bad++; $display("FAIL delay_wait%0d: req=%b addr=%h valid=%b want 1 c 0", k, imem_req, imem_addr, out_valid);
      end
      step(0, 0, (k == 3), 32'h8C22_0010, 0);
    end
    total++;
    if (out_valid !== 1'b1 || instr !== 32'h8C22_0010 || pc_out !== 32'hC || pc_plus4 !== 32'h10) begin
      bad++; $display("FAIL delay_out: valid=%b instr=%h pc=%h want 1 8c220010 c", out_valid, instr, pc_out);
    end
  endtask

  task automatic test_stall;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'h8C22_0010 || pc_out !== 32'hC ||
          imm16 !== 16'h0010 || rs !== 5'd1 || rt !== 5'd2) begin
        bad++; $display("FAIL stall%0d: valid=%b req=%b instr=%h pc=%h", k, out_valid, imem_req, instr, pc_out);
      end
      step(0, 0, 1, 32'hFFFF_FFFF, 0);
    end
    step(0, 0, 0, 0, 1);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10 || out_valid !== 1'b0) begin
      bad++; $display("FAIL stall_release: req=%b addr=%h want 1 10", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_squash;
    step(1, 32'h0000_0103, 0, 0, 0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      bad++; $display("FAIL squash_hold_addr: req=%b addr=%h want 1 10", imem_req, imem_addr);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hDEAD_BEEF, 1);
    total++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      bad++; $display("FAIL squash_discard: valid=%b req=%b addr=%h want 0 1 100", out_valid, imem_req, imem_addr);
    end
    step(0, 0, 1, 32'h0000_0020, 0);
    total++;
    if (out_valid !== 1'b1 || pc_out !== 32'h100 || instr !== 32'h0000_0020 || funct !== 6'h20) begin
      bad++; $display("FAIL squash_next: valid=%b pc=%h instr=%h want 1 100 00000020", out_valid, pc_out, instr);
    end
  endtask

  task automatic test_redirect_hold;
    step(1, 32'h0000_0202, 0, 0, 1);
    total++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      bad++; $display("FAIL redir_hold: valid=%b req=%b addr=%h want 0 1 200", out_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_async_reset;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0 || pc_out !== RPC0 || instr !== 32'h0 || imem_addr !== RPC0) begin
      bad++; $display("FAIL async_reset: req=%b valid=%b pc=%h addr=%h want 0 0 0 0", imem_req, out_valid, pc_out, imem_addr);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== RPC0) begin
      bad++; $display("FAIL async_restart: req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap;
    w_reset_n = 1'b1;
    total++;
    if (w_imem_req !== 1'b0 || w_pc_out !== RPCW || w_pc_plus4 !== 32'h0) begin
      bad++; $display("FAIL wrap_reset: req=%b pc=%h plus4=%h want 0 fffffffc 0", w_imem_req, w_pc_out, w_pc_plus4);
    end
    @(negedge clk);
    total++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== RPCW) begin
      bad++; $display("FAIL wrap_req: req=%b addr=%h want 1 fffffffc", w_imem_req, w_imem_addr);
    end
    w_imem_ack = 1'b1; w_imem_rdata = 32'h3C01_1234; w_out_ready = 1'b1;
    @(negedge clk);
    w_imem_ack = 1'b0;
    total++;
    if (w_out_valid !== 1'b1 || w_pc_out !== RPCW || w_pc_plus4 !== 32'h0) begin
      bad++; $display("FAIL wrap_hold: valid=%b pc=%h plus4=%h want 1 fffffffc 0", w_out_valid, w_pc_out, w_pc_plus4);
    end
    @(negedge clk);
    total++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_next: req=%b addr=%h want 1 0", w_imem_req, w_imem_addr);
    end
  endtask

  task automatic test_random;
    logic [5:0]  op;
    logic [31:0] rdat, rpc;
    logic        exp_ext;
    for (int n = 0; n < 400; n++) begin
      exp_ext = ((m_ir >> 26) >= 12) && ((m_ir >> 26) <= 15);
      total++;
      if (imem_req !== (m_phase == 1) || out_valid !== (m_phase == 2) || imem_addr !== m_addr) begin
        bad++; $display("FAIL rnd_bus%0d: req=%b valid=%b addr=%h want %b %b %h",
                        n, imem_req, out_valid, imem_addr, m_phase == 1, m_phase == 2, m_addr);
      end
      total++;
      if (instr !== m_ir || pc_out !== m_pc_out || pc_plus4 !== m_pc_out + 32'd4) begin
        bad++; $display("FAIL rnd_held%0d: instr=%h pc=%h want %h %h", n, instr, pc_out, m_ir, m_pc_out);
      end
      total++;
      if ({opcode, rs, rt, rd, shamt, funct} !== m_ir || imm16 !== m_ir[15:0] ||
          jaddr !== m_ir[25:0] || ext_sel !== exp_ext) begin
        bad++; $display("FAIL rnd_decode%0d: op=%h imm=%h ext=%b want ir=%h ext=%b", n, opcode, imm16, ext_sel, m_ir, exp_ext);
      end
      if ($urandom_range(0, 1) == 0) op = 6'($urandom_range(11, 16));
      else op = 6'($urandom_range(0, 63));
      rdat = {op, 26'($urandom)};
      rpc  = $urandom;
      step(($urandom_range(0, 15) == 0), rpc, ($urandom_range(0, 1) == 1), rdat,
           ($urandom_range(0, 9) < 6));
    end
  endtask

  initial begin
    reset_n = 1'b1; imem_ack = 0; imem_rdata = 0; redirect = 0; redirect_pc = 0; out_ready = 0;
    w_reset_n = 1'b1; w_imem_ack = 0; w_imem_rdata = 0; w_redirect = 0; w_redirect_pc = 0; w_out_ready = 0;
    #1;
    reset_n = 1'b0; w_reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_stream();
    test_ack_delay();
    test_stall();
    test_redirect_squash();
    test_redirect_hold();
    test_async_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
